// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences DUT reset, strap latching, firmware preload and exit-loop release, then supervises the run with a watchdog.
module sim_run_ctrl #(
  parameter int RESET_WAIT_CYCLES = 50,
  parameter int LOAD_DELAY_CYCLES = 50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        boot_sel_i,
  input  logic        exec_from_flash_i,
  input  logic        jtag_mode_i,
  input  logic [31:0] max_cycles_i,
  output logic        dut_rst_no,
  output logic        boot_sel_o,
  output logic        exec_from_flash_o,
  output logic        load_req_o,
  input  logic        load_ack_i,
  output logic        set_exit_loop_o,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [31:0] exit_value_o,
  output logic [31:0] cycle_cnt_o,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    LOAD_WAIT  = 3'd1,
    LOAD       = 3'd2,
    EXIT_LOOP  = 3'd3,
    RUN        = 3'd4,
    DONE       = 3'd5,
    TIMEOUT    = 3'd6
  } state_t;
  state_t      r_state, w_next;
  logic [31:0] r_phase, r_cycle_cnt, r_exit_value;
  logic        r_dut_rst_n, r_boot_sel, r_exec, r_load_req, r_set_exit;
  logic        r_done, r_pass, r_timeout;
  logic        w_counting, w_next_counting, w_expire;
  assign w_counting      = r_state inside {LOAD_WAIT, LOAD, EXIT_LOOP, RUN};
  assign w_next_counting = w_next inside {LOAD_WAIT, LOAD, EXIT_LOOP, RUN};
  assign w_expire        = w_counting && (max_cycles_i != '0) && (r_cycle_cnt >= max_cycles_i);
  always_comb begin
    w_next = r_state;
    case (r_state)
      RESET_HOLD: w_next = (r_phase == 32'(RESET_WAIT_CYCLES - 1)) ? LOAD_WAIT : RESET_HOLD;
      LOAD_WAIT:  if (r_phase == 32'(LOAD_DELAY_CYCLES - 1)) w_next = (!r_boot_sel && !jtag_mode_i) ? LOAD : RUN;
      LOAD:       w_next = load_ack_i ? EXIT_LOOP : LOAD;
      EXIT_LOOP:  w_next = RUN;
      RUN:        w_next = exit_valid_i ? DONE : RUN;
      default:    w_next = r_state;
    endcase
    // an exit strobe in RUN beats a simultaneous watchdog expiry
    if (w_expire && w_next != DONE) w_next = TIMEOUT;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= RESET_HOLD;
      r_phase      <= '0;
      r_cycle_cnt  <= '0;
      r_exit_value <= '0;
      r_dut_rst_n  <= 1'b0;
      r_boot_sel   <= 1'b0;
      r_exec       <= 1'b0;
      r_load_req   <= 1'b0;
      r_set_exit   <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_phase     <= (w_next == r_state && r_state inside {RESET_HOLD, LOAD_WAIT}) ? r_phase + 32'd1 : '0;
      r_dut_rst_n <= w_next != RESET_HOLD;
      r_load_req  <= w_next == LOAD;
      r_set_exit  <= w_next == EXIT_LOOP;
      r_done      <= w_next inside {DONE, TIMEOUT};
      r_timeout   <= w_next == TIMEOUT;
      if (r_state == RESET_HOLD) begin
        r_boot_sel <= boot_sel_i;
        r_exec     <= boot_sel_i & exec_from_flash_i;
      end
      if (w_counting && w_next_counting && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state == RUN && w_next == DONE) begin
        r_exit_value <= exit_value_i;
        r_pass       <= exit_value_i == '0;
      end
    end
  end
  assign dut_rst_no        = r_dut_rst_n;
  assign boot_sel_o        = r_boot_sel;
  assign exec_from_flash_o = r_exec;
  assign load_req_o        = r_load_req;
  assign set_exit_loop_o   = r_set_exit;
  assign done_o            = r_done;
  assign pass_o            = r_pass;
  assign timeout_o         = r_timeout;
  assign exit_value_o      = r_exit_value;
  assign cycle_cnt_o       = r_cycle_cnt;
  assign state_o           = r_state;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: scoreboard bench; tasks queue expected outputs with their stimulus and drain the queue at each observation point.
module tb_sim_run_ctrl;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        boot_sel_i = 1'b0, exec_from_flash_i = 1'b0, jtag_mode_i = 1'b0;
  logic        load_ack_i = 1'b0, exit_valid_i = 1'b0;
  logic [31:0] max_cycles_i = '0, exit_value_i = '0;
  logic        dut_rst_no, boot_sel_o, exec_from_flash_o, load_req_o, set_exit_loop_o;
  logic        done_o, pass_o, timeout_o;
  logic [31:0] exit_value_o, cycle_cnt_o;
  logic [2:0]  state_o;
  typedef struct {string nm; logic [31:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, req_seen = 0, pulses = 0;

  sim_run_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .boot_sel_i(boot_sel_i), .exec_from_flash_i(exec_from_flash_i),
    .jtag_mode_i(jtag_mode_i), .max_cycles_i(max_cycles_i), .dut_rst_no(dut_rst_no),
    .boot_sel_o(boot_sel_o), .exec_from_flash_o(exec_from_flash_o), .load_req_o(load_req_o),
    .load_ack_i(load_ack_i), .set_exit_loop_o(set_exit_loop_o), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .exit_value_o(exit_value_o), .cycle_cnt_o(cycle_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (load_req_o) req_seen++;
    if (set_exit_loop_o) pulses++;
  end

  function automatic logic [31:0] probe(string nm);
    case (nm)
      "state":  return {29'b0, state_o};
      "rst_n":  return {31'b0, dut_rst_no};
      "boot":   return {31'b0, boot_sel_o};
      "exec":   return {31'b0, exec_from_flash_o};
      "req":    return {31'b0, load_req_o};
      "sel":    return {31'b0, set_exit_loop_o};
      "done":   return {31'b0, done_o};
      "pass":   return {31'b0, pass_o};
      "tmo":    return {31'b0, timeout_o};
      "val":    return exit_value_o;
      "cnt":    return cycle_cnt_o;
      "reqs":   return 32'(req_seen);
      "pulses": return 32'(pulses);
      default:  return 'x;
    endcase
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(string nm, logic [31:0] v);
    sb.push_back('{nm, v});
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(2);
    push("state", 0); push("rst_n", 0); push("cnt", 0); push("done", 0); push("req", 0); push("boot", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL reset/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  task automatic test_preload();
    int p0;
    boot_sel_i = 0; jtag_mode_i = 0; exec_from_flash_i = 0; max_cycles_i = 0;
    apply_reset();
    p0 = pulses;
    step(49);
    push("rst_n", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(1);
    push("rst_n", 1); push("state", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(49);
    push("req", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(1);
    push("req", 1); push("state", 2); push("cnt", 50);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(3);
    load_ack_i = 1;
    step(1);
    load_ack_i = 0;
    push("state", 3); push("sel", 1); push("req", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(1);
    push("state", 4); push("sel", 0); push("cnt", 55);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(10);
    exit_value_i = 0; exit_valid_i = 1;
    step(1);
    exit_valid_i = 0;
    push("state", 5); push("done", 1); push("pass", 1); push("tmo", 0); push("cnt", 65); push("pulses", 32'(p0 + 1));
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL preload/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  task automatic test_flash_boot();
    int r0;
    boot_sel_i = 1; exec_from_flash_i = 1; jtag_mode_i = 0; max_cycles_i = 0;
    apply_reset();
    r0 = req_seen;
    step(50);
    boot_sel_i = 0; exec_from_flash_i = 0;
    push("rst_n", 1); push("boot", 1); push("exec", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL flash/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(49);
    push("state", 1); push("boot", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL flash/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(1);
    push("state", 4); push("reqs", 32'(r0)); push("exec", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL flash/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  task automatic test_fail_code();
    exit_value_i = 32'hDEAD; exit_valid_i = 1;
    step(1);
    exit_valid_i = 0;
    push("state", 5); push("done", 1); push("pass", 0); push("val", 32'hDEAD);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL fail_code/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    exit_value_i = 0; exit_valid_i = 1;
    step(1);
    exit_valid_i = 0;
    step(1);
    push("state", 5); push("done", 1); push("pass", 0); push("val", 32'hDEAD); push("rst_n", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL fail_code/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  task automatic test_jtag();
    int r0;
    boot_sel_i = 0; exec_from_flash_i = 1; jtag_mode_i = 1; max_cycles_i = 0;
    apply_reset();
    r0 = req_seen;
    step(100);
    push("state", 4); push("boot", 0); push("exec", 0); push("reqs", 32'(r0));
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL jtag/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    jtag_mode_i = 0;
  endtask

  task automatic test_reset_mid_run();
    rst_i = 1; boot_sel_i = 1; exec_from_flash_i = 1;
    step(1);
    rst_i = 0;
    push("state", 0); push("rst_n", 0); push("cnt", 0); push("boot", 0); push("exec", 0); push("done", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL reset_mid/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(50);
    push("rst_n", 1); push("boot", 1); push("exec", 1); push("state", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL reset_mid/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(50);
    push("state", 4); push("cnt", 50);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL reset_mid/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  task automatic test_disabled_watchdog();
    int bad = 0;
    max_cycles_i = 0;
    for (int i = 1; i <= 10000; i++) begin
      step(1);
      if (cycle_cnt_o !== 32'(50 + i) || state_o !== 3'd4) bad++;
    end
    n_chk++;
    if (bad == 0) n_pass++; else $display("FAIL disabled_wd/per_cycle: got %0d bad cycles, expected 0", bad);
    push("cnt", 10050); push("state", 4); push("tmo", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL disabled_wd/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  task automatic test_watchdog();
    boot_sel_i = 0; exec_from_flash_i = 0; jtag_mode_i = 0; max_cycles_i = 20;
    apply_reset();
    step(70);
    push("state", 1); push("cnt", 20); push("tmo", 0);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_early/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(1);
    push("state", 6); push("tmo", 1); push("done", 1); push("pass", 0); push("cnt", 20); push("rst_n", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_early/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(5);
    push("state", 6); push("cnt", 20);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_early/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    max_cycles_i = 0;
    apply_reset();
    step(100);
    push("state", 2); push("req", 1);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_load/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    max_cycles_i = 53;
    step(3);
    push("state", 2); push("req", 1); push("cnt", 53);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_load/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    step(1);
    push("state", 6); push("req", 0); push("tmo", 1); push("cnt", 53);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_load/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    boot_sel_i = 1; max_cycles_i = 0;
    apply_reset();
    step(100);
    push("state", 4); push("cnt", 50);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_tie/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
    max_cycles_i = 55;
    step(5);
    exit_value_i = 7; exit_valid_i = 1;
    step(1);
    exit_valid_i = 0;
    push("state", 5); push("done", 1); push("tmo", 0); push("pass", 0); push("val", 7); push("cnt", 55);
    while (sb.size() > 0) begin e = sb.pop_front(); n_chk++; if (probe(e.nm) === e.v) n_pass++; else $display("FAIL wd_tie/%s: got %0h, expected %0h", e.nm, probe(e.nm), e.v); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_flash_boot();
    test_fail_code();
    test_jtag();
    test_reset_mid_run();
    test_disabled_watchdog();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
